// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: divider FSM encodings, iteration count, DIV/DIVU
// opcode/funct constants (also used by the decoder) and a magnitude helper.
package cpu_defs_pkg;

  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU = 6'h1B;

  // Absolute value of a 32-bit operand when treated as signed; raw value otherwise.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    logic signed [31:0] w_sv;
    w_sv = v;
    return (is_signed && w_sv < 0) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration of the radix-2 divider.
module div_step (
  input  logic [32:0] i_rem,
  input  logic        i_bit,
  input  logic [31:0] i_dvs,
  output logic [32:0] o_rem,
  output logic        o_q
);

  logic [33:0] w_shift;
  logic [33:0] w_diff;

  // Shift in the next dividend bit and keep the difference only if it does not borrow.
  always_comb begin
    w_shift = {i_rem, i_bit};
    w_diff  = w_shift - {2'b00, i_dvs};
    o_q     = ~w_diff[33];
    o_rem   = o_q ? w_diff[32:0] : w_shift[32:0];
  end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 DIV/DIVU unit for the execute stage. Produces LO/HI and
// the combinational stall request for the hazard unit.
// Optional feature macro: DIV_EARLY_EXIT_EN (skip iteration when the quotient
// is trivially zero or the divisor is zero).
module div_iter #(
  parameter int DIV_CYCLES = cpu_defs_pkg::DIV_CYCLES
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        stallE,
  input  logic        cancel,
  output logic        div_stall,
  output logic        div_done,
  output logic [31:0] lo,
  output logic [31:0] hi
);

  import cpu_defs_pkg::*;

  localparam int          CW   = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);

  // Two's-complement negate when requested (sign fix of quotient/remainder).
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

  div_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_lo;
  logic [31:0]   r_hi;

  logic [32:0]   r_rem;
  logic [31:0]   r_dvd;
  logic [31:0]   r_dvs;
  logic [31:0]   r_op1;
  logic          r_zero;
  logic          r_neg_q;
  logic          r_neg_r;

  logic          w_start;
  logic          w_early;
  logic [31:0]   w_mag1;
  logic [31:0]   w_mag2;
  logic [32:0]   w_rem_nxt;
  logic          w_q;
  logic [31:0]   w_quo;
  logic [31:0]   w_lo_fix;
  logic [31:0]   w_hi_fix;

  assign w_start = div_start & ~cancel & (r_state == DIV_IDLE);
  assign w_mag1  = mag32(opdata1, div_signed);
  assign w_mag2  = mag32(opdata2, div_signed);

`ifdef DIV_EARLY_EXIT_EN
  assign w_early = (opdata2 == 32'd0) || (w_mag1 < w_mag2);
`else
  assign w_early = 1'b0;
`endif

  div_step u_step (
    .i_rem (r_rem),
    .i_bit (r_dvd[31]),
    .i_dvs (r_dvs),
    .o_rem (w_rem_nxt),
    .o_q   (w_q)
  );

  // The dividend register doubles as the quotient shift register.
  assign w_quo    = {r_dvd[30:0], w_q};
  assign w_lo_fix = r_zero ? 32'hFFFF_FFFF : neg_if(w_quo, r_neg_q);
  assign w_hi_fix = r_zero ? r_op1 : neg_if(w_rem_nxt[31:0], r_neg_r);

  // Control FSM, iteration counter and result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
      r_lo    <= 32'd0;
      r_hi    <= 32'd0;
    end else if (cancel) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (div_start) begin
            r_cnt <= '0;
            if (w_early) begin
              r_state <= DIV_DONE;
              r_lo    <= (opdata2 == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
              r_hi    <= opdata1;
            end else begin
              r_state <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= DIV_DONE;
            r_lo    <= w_lo_fix;
            r_hi    <= w_hi_fix;
          end
        end
        DIV_DONE: begin
          if (!stallE) r_state <= DIV_IDLE;
        end
        default: r_state <= DIV_IDLE;
      endcase
    end
  end

  // Operand latch at start, then one shift-subtract per CALC cycle.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_rem   <= 33'd0;
      r_dvd   <= w_mag1;
      r_dvs   <= w_mag2;
      r_op1   <= opdata1;
      r_zero  <= (opdata2 == 32'd0);
      r_neg_q <= div_signed & (opdata1[31] ^ opdata2[31]);
      r_neg_r <= div_signed & opdata1[31];
    end else if (r_state == DIV_CALC) begin
      r_rem   <= w_rem_nxt;
      r_dvd   <= w_quo;
    end
  end

  assign div_stall = div_start & ~cancel & (r_state != DIV_DONE);
  assign div_done  = (r_state == DIV_DONE);
  assign lo        = r_lo;
  assign hi        = r_hi;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed cases plus randomized divides,
// compared every cycle against a timeline/arithmetic reference model.
module tb_div_iter;

`ifdef DIV_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        div_start;
  logic        div_signed;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        stallE;
  logic        cancel;
  logic        div_stall;
  logic        div_done;
  logic [31:0] lo;
  logic [31:0] hi;

  div_iter dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_start  (div_start),
    .div_signed (div_signed),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .stallE     (stallE),
    .cancel     (cancel),
    .div_stall  (div_stall),
    .div_done   (div_done),
    .lo         (lo),
    .hi         (hi)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall = 1'b0;
  logic        exp_done = 1'b0;
  logic [31:0] exp_lo = 32'd0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] got_lo;
  logic [31:0] got_hi;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference arithmetic: MIPS DIV/DIVU results including the defined corner cases.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                                  output logic [31:0] q, output logic [31:0] r);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  function automatic bit is_early(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint la;
    longint lb;
    if (!EARLY) return 1'b0;
    la = s ? longint'($signed(a)) : longint'(a);
    lb = s ? longint'($signed(b)) : longint'(b);
    if (la < 0) la = -la;
    if (lb < 0) lb = -lb;
    return (b == 32'd0) || (la < lb);
  endfunction

  // Compare process: DUT outputs against the expected timeline every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk1("div_stall", div_stall, exp_stall);
      chk1("div_done", div_done, exp_done);
      chk32("lo", lo, exp_lo);
      chk32("hi", hi, exp_hi);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      div_start = 1'b0;
      cancel    = 1'b0;
      stallE    = 1'b0;
      exp_stall = 1'b0;
      exp_done  = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // One divide from the start cycle; hold = extra DONE cycles under stallE,
  // cancel_at = cycle index of a cancel pulse (-1 for none).
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                         input int hold, input int cancel_at);
    logic [31:0] q;
    logic [31:0] r;
    int lat;
    ref_div(a, b, s, q, r);
    lat = is_early(a, b, s) ? 1 : 33;
    for (int c = 0; c < 200; c++) begin
      if (c == 0) begin
        div_start  = 1'b1;
        div_signed = s;
        opdata1    = a;
        opdata2    = b;
      end else begin
        opdata1    = $urandom;
        opdata2    = $urandom;
        div_signed = 1'($urandom_range(0, 1));
      end
      cancel = (c == cancel_at);
      if (c == cancel_at) begin
        exp_stall = 1'b0;
        exp_done  = 1'b0;
        stallE    = 1'b0;
      end else if (c < lat) begin
        exp_stall = 1'b1;
        exp_done  = 1'b0;
        stallE    = 1'($urandom_range(0, 1));
      end else begin
        exp_stall = 1'b0;
        exp_done  = 1'b1;
        exp_lo    = q;
        exp_hi    = r;
        stallE    = (c - lat < hold);
        @(negedge clk);
        got_lo = lo;
        got_hi = hi;
      end
      @(posedge clk); #1;
      if (c == cancel_at) begin
        idle(1);
        break;
      end
      if (c >= lat && c - lat >= hold) break;
    end
  endtask

  initial begin
    resetn     = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    opdata1    = 32'd0;
    opdata2    = 32'd0;
    stallE     = 1'b0;
    cancel     = 1'b0;

    // Reset state
    @(negedge clk);
    chk1("rst_stall", div_stall, 1'b0);
    chk1("rst_done", div_done, 1'b0);
    chk32("rst_lo", lo, 32'd0);
    chk32("rst_hi", hi, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // DIVU 100 / 7
    run_div(32'd100, 32'd7, 1'b0, 0, -1);
    chk32("divu_100_7_lo", got_lo, 32'd14);
    chk32("divu_100_7_hi", got_hi, 32'd2);
    idle(1);

    // DIV -7 / 2, then DIVU back-to-back on the same operands
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, -1);
    chk32("div_m7_2_lo", got_lo, 32'hFFFF_FFFD);
    chk32("div_m7_2_hi", got_hi, 32'hFFFF_FFFF);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 0, -1);
    chk32("divu_m7_2_lo", got_lo, 32'h7FFF_FFFC);
    chk32("divu_m7_2_hi", got_hi, 32'd1);
    idle(1);

    // Divide by zero and signed overflow
    run_div(32'h1234_5678, 32'd0, 1'b1, 0, -1);
    chk32("divz_lo", got_lo, 32'hFFFF_FFFF);
    chk32("divz_hi", got_hi, 32'h1234_5678);
    idle(1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, -1);
    chk32("ovf_lo", got_lo, 32'h8000_0000);
    chk32("ovf_hi", got_hi, 32'd0);
    idle(1);

    // Cancel in CALC cycle 10 (results held), then a clean divide
    run_div(32'd1000, 32'd3, 1'b0, 0, 10);
    run_div(32'd1000, 32'd3, 1'b0, 0, -1);
    chk32("after_cancel_lo", got_lo, 32'd333);
    chk32("after_cancel_hi", got_hi, 32'd1);
    idle(1);

    // DONE held 3 extra cycles by stallE, then back-to-back start
    run_div(32'd50, 32'hFFFF_FFFB, 1'b1, 3, -1);
    chk32("hold_lo", got_lo, 32'hFFFF_FFF6);
    chk32("hold_hi", got_hi, 32'd0);
    run_div(32'd77, 32'd5, 1'b0, 0, -1);
    chk32("b2b_lo", got_lo, 32'd15);
    chk32("b2b_hi", got_hi, 32'd2);
    idle(1);

    // Small dividend (early exit when enabled)
    run_div(32'd5, 32'd9, 1'b0, 0, -1);
    chk32("small_lo", got_lo, 32'd0);
    chk32("small_hi", got_hi, 32'd5);
    idle(1);

    // Asynchronous reset in the middle of CALC
    div_start  = 1'b1;
    div_signed = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd7;
    exp_stall  = 1'b1;
    exp_done   = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk_en = 1'b0;
    resetn = 1'b0;
    #1;
    chk1("arst_done", div_done, 1'b0);
    chk32("arst_lo", lo, 32'd0);
    chk32("arst_hi", hi, 32'd0);
    chk1("arst_stall", div_stall, 1'b1);
    div_start = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    exp_lo = 32'd0;
    exp_hi = 32'd0;
    exp_stall = 1'b0;
    exp_done  = 1'b0;
    chk_en = 1'b1;
    idle(1);
    run_div(32'd1000, 32'd7, 1'b0, 0, -1);
    idle(1);

    // Randomized divides
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      logic [31:0] b;
      bit s;
      int hold;
      int cat;
      int lat;
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 15));
        3:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 20));
      s    = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 3);
      lat  = is_early(a, b, s) ? 1 : 33;
      cat  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, lat - 1) : -1;
      run_div(a, b, s, hold, cat);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
